// File: rtl/bwt_sa_to_last_column.sv
// BWT last-column builder: latches the text, then turns each incoming suffix-array
// rank into one byte of the last column and records the primary index.
module bwt_sa_to_last_column #(
  parameter int STRING_LEN  = 32,
  parameter int ELEMENT_LEN = 8,
  parameter int IDX_W       = $clog2(STRING_LEN)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [STRING_LEN*ELEMENT_LEN-1:0] text_in,
  input  logic                              sa_valid,
  input  logic [IDX_W-1:0]                  sa_index,
  output logic                              sa_ready,
  output logic [STRING_LEN*ELEMENT_LEN-1:0] bwt_out,
  output logic [IDX_W-1:0]                  primary_idx,
  output logic                              busy,
  output logic                              done,
  output logic                              range_err,
  output logic                              no_primary
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]                        state;
  logic [STRING_LEN*ELEMENT_LEN-1:0] text_q;
  logic [IDX_W:0]                    cnt;
  logic                              seen;

  logic                   accept, is_zero, in_range, last;
  logic [IDX_W-1:0]       k_m1;
  logic [ELEMENT_LEN-1:0] ch;

  assign accept   = (state == COLLECT) && sa_valid && sa_ready;
  assign is_zero  = (sa_index == '0);
  assign in_range = ({1'b0, sa_index} < (IDX_W+1)'(STRING_LEN));
  assign k_m1     = sa_index - IDX_W'(1);
  assign last     = (cnt == (IDX_W+1)'(STRING_LEN-1));

  // k==0 wraps to the terminator explicitly, so no modulo is needed
  always_comb begin
    ch = '0;
    if (is_zero)
      ch = text_q[ELEMENT_LEN*(STRING_LEN-1) +: ELEMENT_LEN];
    else if (in_range)
      ch = text_q[ELEMENT_LEN*int'(k_m1) +: ELEMENT_LEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      text_q      <= '0;
      cnt         <= '0;
      seen        <= 1'b0;
      sa_ready    <= 1'b0;
      bwt_out     <= '0;
      primary_idx <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      range_err   <= 1'b0;
      no_primary  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            text_q      <= text_in;
            bwt_out     <= '0;
            primary_idx <= '0;
            range_err   <= 1'b0;
            no_primary  <= 1'b0;
            done        <= 1'b0;
            seen        <= 1'b0;
            cnt         <= '0;
            busy        <= 1'b1;
            sa_ready    <= 1'b1;
            state       <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            bwt_out[ELEMENT_LEN*int'(cnt[IDX_W-1:0]) +: ELEMENT_LEN] <= ch;
            if (is_zero) begin
              primary_idx <= cnt[IDX_W-1:0];
              seen        <= 1'b1;
            end
            if (!in_range) range_err <= 1'b1;
            cnt <= cnt + 1'b1;
            if (last) begin
              sa_ready   <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              no_primary <= ~(seen | is_zero);
              state      <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bwt_sa_to_last_column.md
Name: bwt_sa_to_last_column

Overview:
- Stage directly downstream of the suffix-array sorter inside the BWT core.
- Latches the packed input string, then consumes the sorter's suffix-array indices one per handshake.
- Builds the BWT last column, where bwt[i] = text[(sa[i]-1) mod N], and records the primary index (position where sa[i]==0).
- Presents the packed result plus status flags to the top-level result register.

Parameters:
STRING_LEN, 32, number of characters N in the string (including terminator).
ELEMENT_LEN, 8, bits per character.
IDX_W, $clog2(STRING_LEN), width of a suffix-array index.

Ports:
clk  input  1  system clock.
rst  input  1  reset; asynchronous, active-high.
start  input  1  single-cycle request; latches text_in and begins collection.
text_in  input  STRING_LEN*ELEMENT_LEN  packed string; char i at bits [ELEMENT_LEN*i +: ELEMENT_LEN].
sa_valid  input  1  sorter presents a suffix-array entry.
sa_index  input  IDX_W  suffix-array entry, rank order 0..N-1.
sa_ready  output  1  block accepts sa_index this cycle.
bwt_out  output  STRING_LEN*ELEMENT_LEN  packed last column, same byte packing as text_in.
primary_idx  output  IDX_W  rank i where sa[i]==0.
busy  output  1  collection in progress.
done  output  1  result valid; level signal.
range_err  output  1  sticky; some sa_index >= STRING_LEN.
no_primary  output  1  set at completion if no sa_index==0 was received.

Behaviour:
- Reset values (async assert, all outputs registered):
  - bwt_out=0, primary_idx=0.
  - sa_ready=0, busy=0, done=0, range_err=0, no_primary=0.
  - FSM=IDLE, rank counter=0.
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - start=1 → latch text_in to internal text register.
  - Clear bwt_out, primary_idx, range_err, no_primary, done, and the primary-seen flag.
  - Set counter=0, busy=1, sa_ready=1; next state COLLECT.
  - sa_ready is registered, so it is high from the cycle after start.
- COLLECT: an accept is sa_valid && sa_ready. On accept at rank c=counter:
  - sa_index k == 0 → bwt byte c = text[N-1]; primary_idx=c; primary-seen=1.
  - 1 <= k < N → bwt byte c = text[k-1].
  - k >= N → bwt byte c = 0; range_err=1 (sticky until next start).
  - counter increments. The accept with c==N-1 drops sa_ready and busy next cycle, goes to DONE, and sets done=1.
  - On that same edge, no_primary = ~(primary-seen, including the current accept).
  - Latency: done rises exactly 1 cycle after the final accept. Total time is N accepts plus stalls.
  - sa_valid low → stall with no state change; there is no timeout.
  - Multiple k==0 entries: the last one wins primary_idx; no error is flagged.
  - start during COLLECT is ignored; text and counter are unchanged.
- DONE:
  - Outputs hold; done stays 1 and sa_ready stays 0.
  - start=1 → behaves exactly as start in IDLE (done cleared the next cycle, new collection begins).
  - sa_valid in DONE is not accepted.
- rst mid-operation: immediate return to IDLE with reset values; the partial result is discarded.
- Arithmetic:
  - counter is IDX_W+1 bits wide; it never wraps within a run.
  - The k-1 subtraction is done in IDX_W bits, with k==0 handled explicitly (no modulo hardware).
- Byte writes use an indexed part-select on the registered bwt_out; only byte c is written per accept.

Test Plan:
1. STRING_LEN=7, text "banana$" (byte0='b'), start, SA 6,5,3,1,0,4,2 with sa_valid held high → bwt_out bytes "annb$aa" (0x61,0x6E,0x6E,0x62,0x24,0x61,0x61); primary_idx=4; done 1 cycle after 7th accept; range_err=0, no_primary=0.
2. Default N=32, text 31×'a'+'$', SA 31,30,...,0 with sa_valid toggling every other cycle → byte0='a', bytes 1..30='a', byte31='$'; primary_idx=31; done only after 32 accepts; sa_ready never high in IDLE/DONE.
3. N=7, as scenario 1, but sa_index=7 at rank 2 → byte2=0x00, range_err=1; with no 0 sent, no_primary=1 at done.
4. Reset pulse (async, mid-clock) after 3 accepts → all outputs 0 immediately, FSM IDLE; a following full run as scenario 1 gives the correct result.
5. start pulses at cycle 2 of COLLECT and while in DONE → ignored in COLLECT (result still "annb$aa"); in DONE clears done next cycle and a new run with a different text produces the new column.
